// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one main-memory burst port between the I-cache (port 0)
// and D-cache (port 1), with round-robin tie-break, writeback lock and stall flag.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH = 21,
    parameter int DATA_WIDTH    = 32,
    parameter bit WB_LOCK       = 1'b1,
    parameter int TIMEOUT       = 1023
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,

    input  logic                     i_P0_Valid,
    input  logic                     i_P0_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_P0_Address,
    input  logic [DATA_WIDTH-1:0]    i_P0_Data,
    output logic                     o_P0_MEM_Valid,
    output logic                     o_P0_MEM_Data_Read,
    output logic                     o_P0_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_P0_MEM_Data,

    input  logic                     i_P1_Valid,
    input  logic                     i_P1_Read_Write_n,
    input  logic [ADDRESS_WIDTH-1:0] i_P1_Address,
    input  logic [DATA_WIDTH-1:0]    i_P1_Data,
    output logic                     o_P1_MEM_Valid,
    output logic                     o_P1_MEM_Data_Read,
    output logic                     o_P1_MEM_Last,
    output logic [DATA_WIDTH-1:0]    o_P1_MEM_Data,

    output logic                     o_MEM_Valid,
    output logic                     o_MEM_Read_Write_n,
    output logic [ADDRESS_WIDTH-1:0] o_MEM_Address,
    output logic [DATA_WIDTH-1:0]    o_MEM_Data,
    input  logic                     i_MEM_Valid,
    input  logic                     i_MEM_Data_Read,
    input  logic                     i_MEM_Last,
    input  logic [DATA_WIDTH-1:0]    i_MEM_Data,

    output logic [1:0]               o_Grant,
    output logic                     o_Timeout
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

    state_t             state, state_next;
    logic               rr_ptr, rr_ptr_next;
    logic [CNT_W-1:0]   stall_cnt, stall_cnt_next;
    logic               timeout_q;

    logic                     granted;
    logic                     sel_valid;
    logic                     sel_rw;
    logic [ADDRESS_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0]    sel_data;

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state     <= IDLE;
            rr_ptr    <= 1'b0;
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            rr_ptr    <= rr_ptr_next;
            stall_cnt <= stall_cnt_next;
            timeout_q <= timeout_q | (stall_cnt == CNT_MAX);
        end
    end

    always_comb begin
        granted   = (state != IDLE);
        sel_valid = (state == GRANT1) ? i_P1_Valid        : i_P0_Valid;
        sel_rw    = (state == GRANT1) ? i_P1_Read_Write_n : i_P0_Read_Write_n;
        sel_addr  = (state == GRANT1) ? i_P1_Address      : i_P0_Address;
        sel_data  = (state == GRANT1) ? i_P1_Data         : i_P0_Data;

        state_next  = state;
        rr_ptr_next = rr_ptr;
        case (state)
            IDLE: begin
                if (i_P0_Valid && i_P1_Valid) begin
                    state_next  = rr_ptr ? GRANT1 : GRANT0;
                    rr_ptr_next = ~rr_ptr;
                end else if (i_P0_Valid) begin
                    state_next = GRANT0;
                end else if (i_P1_Valid) begin
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                // A write ending while the port still requests keeps the grant for its line fill
                if (!sel_valid) begin
                    state_next = IDLE;
                end else if (i_MEM_Last && !(WB_LOCK && !sel_rw)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        stall_cnt_next = '0;
        if (granted && !i_MEM_Valid && !i_MEM_Data_Read) begin
            stall_cnt_next = (stall_cnt == CNT_MAX) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    always_comb begin
        o_MEM_Valid        = granted & sel_valid;
        o_MEM_Read_Write_n = granted & sel_rw;
        o_MEM_Address      = granted ? sel_addr : '0;
        o_MEM_Data         = granted ? sel_data : '0;

        o_P0_MEM_Valid     = (state == GRANT0) & i_MEM_Valid;
        o_P0_MEM_Data_Read = (state == GRANT0) & i_MEM_Data_Read;
        o_P0_MEM_Last      = (state == GRANT0) & i_MEM_Last;
        o_P0_MEM_Data      = i_MEM_Data;

        o_P1_MEM_Valid     = (state == GRANT1) & i_MEM_Valid;
        o_P1_MEM_Data_Read = (state == GRANT1) & i_MEM_Data_Read;
        o_P1_MEM_Last      = (state == GRANT1) & i_MEM_Last;
        o_P1_MEM_Data      = i_MEM_Data;

        o_Grant   = {state == GRANT1, state == GRANT0};
        o_Timeout = timeout_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed per-cycle vectors drive both ports and memory,
// a negedge monitor matches every forwarded response against the expected queue.
module tb_mem_arbiter;

    logic        clk;
    logic        i_Reset_n;
    logic        i_P0_Valid, i_P0_Read_Write_n;
    logic [20:0] i_P0_Address;
    logic [31:0] i_P0_Data;
    logic        i_P1_Valid, i_P1_Read_Write_n;
    logic [20:0] i_P1_Address;
    logic [31:0] i_P1_Data;
    logic        i_MEM_Valid, i_MEM_Data_Read, i_MEM_Last;
    logic [31:0] i_MEM_Data;

    logic        o_P0_MEM_Valid, o_P0_MEM_Data_Read, o_P0_MEM_Last;
    logic [31:0] o_P0_MEM_Data;
    logic        o_P1_MEM_Valid, o_P1_MEM_Data_Read, o_P1_MEM_Last;
    logic [31:0] o_P1_MEM_Data;
    logic        o_MEM_Valid, o_MEM_Read_Write_n;
    logic [20:0] o_MEM_Address;
    logic [31:0] o_MEM_Data;
    logic [1:0]  o_Grant;
    logic        o_Timeout;

    logic        nl_P0_MEM_Valid, nl_P0_MEM_Data_Read, nl_P0_MEM_Last;
    logic [31:0] nl_P0_MEM_Data;
    logic        nl_P1_MEM_Valid, nl_P1_MEM_Data_Read, nl_P1_MEM_Last;
    logic [31:0] nl_P1_MEM_Data;
    logic        nl_MEM_Valid, nl_MEM_Read_Write_n;
    logic [20:0] nl_MEM_Address;
    logic [31:0] nl_MEM_Data;
    logic [1:0]  nl_Grant;
    logic        nl_Timeout;

    mem_arbiter #(.ADDRESS_WIDTH(21), .DATA_WIDTH(32), .WB_LOCK(1'b1), .TIMEOUT(1023)) dut (
        .i_Clk(clk), .i_Reset_n(i_Reset_n),
        .i_P0_Valid(i_P0_Valid), .i_P0_Read_Write_n(i_P0_Read_Write_n),
        .i_P0_Address(i_P0_Address), .i_P0_Data(i_P0_Data),
        .o_P0_MEM_Valid(o_P0_MEM_Valid), .o_P0_MEM_Data_Read(o_P0_MEM_Data_Read),
        .o_P0_MEM_Last(o_P0_MEM_Last), .o_P0_MEM_Data(o_P0_MEM_Data),
        .i_P1_Valid(i_P1_Valid), .i_P1_Read_Write_n(i_P1_Read_Write_n),
        .i_P1_Address(i_P1_Address), .i_P1_Data(i_P1_Data),
        .o_P1_MEM_Valid(o_P1_MEM_Valid), .o_P1_MEM_Data_Read(o_P1_MEM_Data_Read),
        .o_P1_MEM_Last(o_P1_MEM_Last), .o_P1_MEM_Data(o_P1_MEM_Data),
        .o_MEM_Valid(o_MEM_Valid), .o_MEM_Read_Write_n(o_MEM_Read_Write_n),
        .o_MEM_Address(o_MEM_Address), .o_MEM_Data(o_MEM_Data),
        .i_MEM_Valid(i_MEM_Valid), .i_MEM_Data_Read(i_MEM_Data_Read),
        .i_MEM_Last(i_MEM_Last), .i_MEM_Data(i_MEM_Data),
        .o_Grant(o_Grant), .o_Timeout(o_Timeout)
    );

    // Same stimulus into a copy built without the writeback lock
    mem_arbiter #(.ADDRESS_WIDTH(21), .DATA_WIDTH(32), .WB_LOCK(1'b0), .TIMEOUT(1023)) dutNoLock (
        .i_Clk(clk), .i_Reset_n(i_Reset_n),
        .i_P0_Valid(i_P0_Valid), .i_P0_Read_Write_n(i_P0_Read_Write_n),
        .i_P0_Address(i_P0_Address), .i_P0_Data(i_P0_Data),
        .o_P0_MEM_Valid(nl_P0_MEM_Valid), .o_P0_MEM_Data_Read(nl_P0_MEM_Data_Read),
        .o_P0_MEM_Last(nl_P0_MEM_Last), .o_P0_MEM_Data(nl_P0_MEM_Data),
        .i_P1_Valid(i_P1_Valid), .i_P1_Read_Write_n(i_P1_Read_Write_n),
        .i_P1_Address(i_P1_Address), .i_P1_Data(i_P1_Data),
        .o_P1_MEM_Valid(nl_P1_MEM_Valid), .o_P1_MEM_Data_Read(nl_P1_MEM_Data_Read),
        .o_P1_MEM_Last(nl_P1_MEM_Last), .o_P1_MEM_Data(nl_P1_MEM_Data),
        .o_MEM_Valid(nl_MEM_Valid), .o_MEM_Read_Write_n(nl_MEM_Read_Write_n),
        .o_MEM_Address(nl_MEM_Address), .o_MEM_Data(nl_MEM_Data),
        .i_MEM_Valid(i_MEM_Valid), .i_MEM_Data_Read(i_MEM_Data_Read),
        .i_MEM_Last(i_MEM_Last), .i_MEM_Data(i_MEM_Data),
        .o_Grant(nl_Grant), .o_Timeout(nl_Timeout)
    );

    typedef struct packed {
        logic        p0v;
        logic [20:0] p0a;
        logic        p1v;
        logic        p1rw;
        logic [20:0] p1a;
        logic [31:0] p1d;
        logic        mv;
        logic        mdr;
        logic        ml;
        logic [31:0] md;
        logic [1:0]  eG;
        logic        eMv;
        logic        eRw;
        logic [20:0] eA;
        logic [1:0]  fwd;
        logic        nlChk;
        logic [1:0]  eNl;
    } vec_t;

    typedef struct packed {
        logic        port;
        logic        isRead;
        logic        last;
        logic [31:0] data;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];
    int    checks = 0;
    int    errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, run did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [31:0] p0v, p0a, p1v, p1rw, p1a, p1d, mv, mdr, ml, md,
                          input logic [31:0] eG, eMv, eRw, eA, fwd, nlChk, eNl);
        vec_t v;
        v.p0v = p0v[0];   v.p0a = p0a[20:0];
        v.p1v = p1v[0];   v.p1rw = p1rw[0]; v.p1a = p1a[20:0]; v.p1d = p1d;
        v.mv = mv[0];     v.mdr = mdr[0];   v.ml = ml[0];      v.md = md;
        v.eG = eG[1:0];   v.eMv = eMv[0];   v.eRw = eRw[0];    v.eA = eA[20:0];
        v.fwd = fwd[1:0]; v.nlChk = nlChk[0]; v.eNl = eNl[1:0];
        vecs.push_back(v);
    endtask

    task automatic clearInputs();
        i_P0_Valid = 1'b0; i_P0_Read_Write_n = 1'b1; i_P0_Address = '0; i_P0_Data = 32'hC0C0_0000;
        i_P1_Valid = 1'b0; i_P1_Read_Write_n = 1'b1; i_P1_Address = '0; i_P1_Data = '0;
        i_MEM_Valid = 1'b0; i_MEM_Data_Read = 1'b0; i_MEM_Last = 1'b0; i_MEM_Data = '0;
    endtask

    // Drive one cycle of inputs just after the edge and record any response the DUT owes
    task automatic applyStimulus(input vec_t v);
        resp_t r;
        @(posedge clk);
        #1;
        i_P0_Valid = v.p0v; i_P0_Read_Write_n = 1'b1; i_P0_Address = v.p0a;
        i_P1_Valid = v.p1v; i_P1_Read_Write_n = v.p1rw; i_P1_Address = v.p1a; i_P1_Data = v.p1d;
        i_MEM_Valid = v.mv; i_MEM_Data_Read = v.mdr; i_MEM_Last = v.ml; i_MEM_Data = v.md;
        if (v.fwd != 2'd0 && (v.mv || v.mdr)) begin
            r.port = (v.fwd == 2'd2);
            r.isRead = v.mv;
            r.last = v.ml;
            r.data = v.md;
            sb.push_back(r);
        end
    endtask

    task automatic runRows(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("grant[%0d]", i), 32'(o_Grant), 32'(vecs[i].eG));
            checkOutput($sformatf("memValid[%0d]", i), 32'(o_MEM_Valid), 32'(vecs[i].eMv));
            if (vecs[i].eMv) begin
                checkOutput($sformatf("memAddr[%0d]", i), 32'(o_MEM_Address), 32'(vecs[i].eA));
                checkOutput($sformatf("memRw[%0d]", i), 32'(o_MEM_Read_Write_n), 32'(vecs[i].eRw));
                if (!vecs[i].eRw)
                    checkOutput($sformatf("memWdata[%0d]", i), o_MEM_Data, vecs[i].p1d);
            end
            if (vecs[i].nlChk)
                checkOutput($sformatf("noLockGrant[%0d]", i), 32'(nl_Grant), 32'(vecs[i].eNl));
        end
    endtask

    task automatic resetDut();
        i_Reset_n = 1'b0;
        clearInputs();
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("resetGrant", 32'(o_Grant), 32'd0);
        checkOutput("resetTimeout", 32'(o_Timeout), 32'd0);
        checkOutput("resetMemValid", 32'(o_MEM_Valid), 32'd0);
        i_Reset_n = 1'b1;
    endtask

    task automatic monitorPort(input int port, input logic v, input logic dr, input logic last,
                               input logic [31:0] data);
        resp_t e;
        if (v || dr || last) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedResp: port%0d got valid=%0b dataRead=%0b last=%0b, expected no response",
                         port, v, dr, last);
            end else begin
                e = sb.pop_front();
                checkOutput("respPort", 32'(port), 32'(e.port));
                checkOutput("respKind", 32'(v), 32'(e.isRead));
                checkOutput("respLast", 32'(last), 32'(e.last));
                if (e.isRead)
                    checkOutput("respData", data, e.data);
            end
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (i_Reset_n) begin
                monitorPort(0, o_P0_MEM_Valid, o_P0_MEM_Data_Read, o_P0_MEM_Last, o_P0_MEM_Data);
                monitorPort(1, o_P1_MEM_Valid, o_P1_MEM_Data_Read, o_P1_MEM_Last, o_P1_MEM_Data);
            end
        end
    end

    int m0, m1, m2, m3, m4, m5, m6, m7;

    initial begin
        i_Reset_n = 1'b0;
        clearInputs();

        // Single P0 read burst, a stray beat in IDLE, then two ties showing round-robin
        m0 = vecs.size();
        addVec(1,'h10, 0,1,0,0, 0,0,0,0,     0,0,0,0,     0,0,0);
        addVec(1,'h10, 0,1,0,0, 0,0,0,0,     1,1,1,'h10,  0,0,0);
        addVec(1,'h10, 0,1,0,0, 1,0,0,'hA0,  1,1,1,'h10,  1,0,0);
        addVec(1,'h10, 0,1,0,0, 1,0,0,'hA1,  1,1,1,'h10,  1,0,0);
        addVec(1,'h10, 0,1,0,0, 1,0,0,'hA2,  1,1,1,'h10,  1,0,0);
        addVec(1,'h10, 0,1,0,0, 1,0,1,'hA3,  1,1,1,'h10,  1,0,0);
        addVec(0,0,    0,1,0,0, 1,0,0,'hEE,  0,0,0,0,     0,0,0);
        addVec(1,'h20, 1,1,'h40,0, 0,0,0,0,    0,0,0,0,     0,0,0);
        addVec(1,'h20, 1,1,'h40,0, 0,0,0,0,    1,1,1,'h20,  0,0,0);
        addVec(1,'h20, 1,1,'h40,0, 1,0,0,'hB0, 1,1,1,'h20,  1,0,0);
        addVec(1,'h20, 1,1,'h40,0, 1,0,1,'hB1, 1,1,1,'h20,  1,0,0);
        addVec(0,0,    1,1,'h40,0, 0,0,0,0,    0,0,0,0,     0,0,0);
        addVec(0,0,    1,1,'h40,0, 0,0,0,0,    2,1,1,'h40,  0,0,0);
        addVec(0,0,    1,1,'h40,0, 1,0,0,'hC0, 2,1,1,'h40,  2,0,0);
        addVec(0,0,    1,1,'h40,0, 1,0,1,'hC1, 2,1,1,'h40,  2,0,0);
        addVec(0,0,    0,1,0,0,    0,0,0,0,    0,0,0,0,     0,0,0);
        addVec(1,'h20, 1,1,'h40,0, 0,0,0,0,    0,0,0,0,     0,0,0);
        addVec(1,'h20, 1,1,'h40,0, 0,0,0,0,    2,1,1,'h40,  0,0,0);
        addVec(1,'h20, 1,1,'h40,0, 1,0,1,'hD0, 2,1,1,'h40,  2,0,0);
        addVec(1,'h20, 0,1,0,0,    0,0,0,0,    0,0,0,0,     0,0,0);
        addVec(1,'h20, 0,1,0,0,    0,0,0,0,    1,1,1,'h20,  0,0,0);
        addVec(1,'h20, 0,1,0,0,    1,0,1,'hE0, 1,1,1,'h20,  1,0,0);
        addVec(0,0,    0,1,0,0,    0,0,0,0,    0,0,0,0,     0,0,0);

        // P1 writeback followed by its fill while P0 waits, then P0 abort after two beats
        m1 = vecs.size();
        addVec(0,0,    1,0,'h200,'h57000, 0,0,0,0,     0,0,0,0,      0,1,0);
        addVec(0,0,    1,0,'h200,'h57000, 0,0,0,0,     2,1,0,'h200,  0,1,2);
        addVec(1,'h30, 1,0,'h200,'h57000, 0,1,0,0,     2,1,0,'h200,  2,1,2);
        addVec(1,'h30, 1,0,'h200,'h57001, 0,1,0,0,     2,1,0,'h200,  2,1,2);
        addVec(1,'h30, 1,0,'h200,'h57002, 0,1,0,0,     2,1,0,'h200,  2,1,2);
        addVec(1,'h30, 1,0,'h200,'h57003, 0,1,1,0,     2,1,0,'h200,  2,1,2);
        addVec(1,'h30, 1,1,'h300,0,       0,0,0,0,     2,1,1,'h300,  0,1,0);
        addVec(1,'h30, 1,1,'h300,0,       1,0,0,'hF0,  2,1,1,'h300,  2,1,1);
        addVec(1,'h30, 1,1,'h300,0,       1,0,1,'hF1,  2,1,1,'h300,  2,0,0);
        addVec(1,'h30, 0,1,0,0,           0,0,0,0,     0,0,0,0,      0,0,0);
        addVec(1,'h30, 0,1,0,0,           0,0,0,0,     1,1,1,'h30,   0,0,0);
        addVec(1,'h30, 0,1,0,0,           1,0,1,'h61,  1,1,1,'h30,   1,0,0);
        addVec(0,0,    0,1,0,0,           0,0,0,0,     0,0,0,0,      0,0,0);
        addVec(1,'h50, 0,1,0,0, 0,0,0,0,     0,0,0,0,     0,0,0);
        addVec(1,'h50, 0,1,0,0, 0,0,0,0,     1,1,1,'h50,  0,0,0);
        addVec(1,'h50, 0,1,0,0, 1,0,0,'h70,  1,1,1,'h50,  1,0,0);
        addVec(1,'h50, 0,1,0,0, 1,0,0,'h71,  1,1,1,'h50,  1,0,0);
        addVec(0,0,    0,1,0,0, 0,0,0,0,     1,0,0,0,     0,0,0);
        addVec(0,0,    0,1,0,0, 1,0,0,'h72,  0,0,0,0,     0,0,0);
        addVec(0,0,    0,1,0,0, 1,0,1,'h73,  0,0,0,0,     0,0,0);
        addVec(0,0,    0,1,0,0, 0,0,0,0,     0,0,0,0,     0,0,0);

        // Tie moves pointer to P1, P1 burst interrupted by reset
        m2 = vecs.size();
        addVec(1,'h60, 1,1,'h70,0, 0,0,0,0,     0,0,0,0,     0,0,0);
        addVec(1,'h60, 1,1,'h70,0, 0,0,0,0,     1,1,1,'h60,  0,0,0);
        addVec(1,'h60, 1,1,'h70,0, 1,0,1,'h80,  1,1,1,'h60,  1,0,0);
        addVec(0,0,    1,1,'h70,0, 0,0,0,0,     0,0,0,0,     0,0,0);
        addVec(0,0,    1,1,'h70,0, 0,0,0,0,     2,1,1,'h70,  0,0,0);
        addVec(0,0,    1,1,'h70,0, 1,0,0,'h81,  2,1,1,'h70,  2,0,0);

        // After reset the tie must go to P0 again
        m3 = vecs.size();
        addVec(1,'h60, 1,1,'h70,0, 0,0,0,0,     1,1,1,'h60,  0,0,0);
        addVec(1,'h60, 1,1,'h70,0, 1,0,1,'h82,  1,1,1,'h60,  1,0,0);
        addVec(0,0,    1,1,'h70,0, 0,0,0,0,     0,0,0,0,     0,0,0);
        addVec(0,0,    1,1,'h70,0, 0,0,0,0,     2,1,1,'h70,  0,0,0);
        addVec(0,0,    1,1,'h70,0, 1,0,1,'h83,  2,1,1,'h70,  2,0,0);
        addVec(0,0,    0,1,0,0,    0,0,0,0,     0,0,0,0,     0,0,0);

        // P1 granted and starved by memory
        m4 = vecs.size();
        addVec(0,0, 1,1,'h80,0, 0,0,0,0,     0,0,0,0,     0,0,0);
        addVec(0,0, 1,1,'h80,0, 0,0,0,0,     2,1,1,'h80,  0,0,0);
        m5 = vecs.size();
        addVec(0,0, 1,1,'h80,0, 1,0,1,'h90,  2,1,1,'h80,  2,0,0);
        addVec(0,0, 0,1,0,0,    0,0,0,0,     0,0,0,0,     0,0,0);
        m6 = vecs.size();
        m7 = m6;

        resetDut();
        runRows(m0, m1);

        resetDut();
        runRows(m1, m2);

        resetDut();
        runRows(m2, m3);
        @(posedge clk);
        #1;
        i_MEM_Valid = 1'b1; i_MEM_Data = 32'h99; i_MEM_Last = 1'b0;
        #2;
        i_Reset_n = 1'b0;
        #1;
        checkOutput("asyncResetGrant", 32'(o_Grant), 32'd0);
        checkOutput("asyncResetMemValid", 32'(o_MEM_Valid), 32'd0);
        checkOutput("asyncResetP1Valid", 32'(o_P1_MEM_Valid), 32'd0);
        checkOutput("asyncResetMemAddr", 32'(o_MEM_Address), 32'd0);
        i_MEM_Valid = 1'b0;
        i_P0_Valid = 1'b1; i_P0_Address = 21'h60;
        @(negedge clk);
        #1;
        i_Reset_n = 1'b1;
        runRows(m3, m4);

        resetDut();
        runRows(m4, m5);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        checkOutput("timeoutEarly", 32'(o_Timeout), 32'd0);
        for (int n = 0; n < 100 && !o_Timeout; n++) @(negedge clk);
        checkOutput("timeoutSet", 32'(o_Timeout), 32'd1);
        checkOutput("timeoutGrantHeld", 32'(o_Grant), 32'd2);
        runRows(m5, m6);
        repeat (3) @(negedge clk);
        checkOutput("timeoutSticky", 32'(o_Timeout), 32'd1);
        checkOutput("sbEmpty", 32'(sb.size()), 32'(m7 - m6));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
